fpu_div: RTL and testbench

- Iterative IEEE 754 floating-point divider (result = a / b) for half and single precision. It is the inverse counterpart of the combinational add/mul FPU.
- Sits beside the FPU in the execute stage and accepts one operation at a time through a valid/ready handshake.
- Produces one quotient bit per cycle. Rounding is truncation and denormals are flushed to zero, matching existing FPU numerics.

---
 rtl/fpu_pkg.sv | 76 +++++++
 rtl/fpu_mant_div.sv | 59 +++++
 rtl/fpu_div.sv | 159 +++++++++++++++
 tb/tb_fpu_div.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the iterative FP divider: field widths, biases,
// canonical encodings, iteration counts, FSM states and pack/unpack helpers.
package fpu_pkg;

   localparam int SP_EXP_W = 8;
   localparam int SP_MAN_W = 23;
   localparam int HP_EXP_W = 5;
   localparam int HP_MAN_W = 10;
   localparam int SIG_W    = SP_MAN_W + 1;

   localparam logic signed [9:0] SP_BIAS = 10'sd127;
   localparam logic signed [9:0] HP_BIAS = 10'sd15;
   localparam logic signed [9:0] SP_EMAX = 10'sd255;
   localparam logic signed [9:0] HP_EMAX = 10'sd31;

   localparam logic [31:0] NAN_SP = 32'h7FC0_0000;
   localparam logic [31:0] NAN_HP = 32'h0000_7E00;
   localparam logic [31:0] INF_SP = 32'h7F80_0000;
   localparam logic [31:0] INF_HP = 32'h0000_7C00;

   localparam int ITER_SP = 25;
   localparam int ITER_HP = 12;
   localparam int CNT_W   = 5;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      NORM,
      DONE
   } state_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
      logic        is_zero;
      logic        is_inf;
      logic        is_nan;
   } fp_fields_t;

   // Half operands are widened into the single-precision field layout;
   // exponent zero is treated as zero regardless of mantissa (denormal flush).
   function automatic fp_fields_t fp_unpack(input logic [31:0] x, input logic single);
      fp_fields_t f;
      logic       all_ones;
      if (single) begin
         f.sign   = x[31];
         f.exp    = x[30:23];
         f.man    = x[22:0];
         all_ones = (x[30:23] == 8'hFF);
      end else begin
         f.sign   = x[15];
         f.exp    = {3'b000, x[14:10]};
         f.man    = {13'd0, x[9:0]};
         all_ones = (x[14:10] == 5'h1F);
      end
      f.is_zero = (f.exp == 8'd0);
      f.is_inf  = all_ones && (f.man == 23'd0);
      f.is_nan  = all_ones && (f.man != 23'd0);
      return f;
   endfunction

   function automatic logic [31:0] fp_pack(input logic single, input logic sign,
                                           input logic [7:0] exp, input logic [22:0] man);
      return single ? {sign, exp, man} : {16'd0, sign, exp[4:0], man[9:0]};
   endfunction

   function automatic logic [31:0] fp_inf(input logic single, input logic sign);
      return single ? (INF_SP | {sign, 31'd0}) : (INF_HP | {16'd0, sign, 15'd0});
   endfunction

   function automatic logic [31:0] fp_zero(input logic single, input logic sign);
      return fp_pack(single, sign, 8'd0, 23'd0);
   endfunction

endpackage

// File: rtl/fpu_mant_div.sv
// Iterative restoring significand divider: one quotient bit per clock, MSB
// first. done is high during the final iteration cycle.
module fpu_mant_div
   import fpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [SIG_W-1:0] dividend,
   input  logic [SIG_W-1:0] divisor,
   input  logic [CNT_W-1:0] iters,
   output logic [SIG_W:0]   quotient,
   output logic             done
);

   logic [SIG_W:0]   rem_q;
   logic [SIG_W-1:0] div_q;
   logic [SIG_W:0]   quo_q;
   logic [CNT_W-1:0] cnt_q;
   logic [SIG_W:0]   diff;
   logic [SIG_W-1:0] rem_nxt;

   // The remainder stays below twice the divisor, so the top bit of the
   // difference is a reliable borrow flag.
   assign diff = rem_q - {1'b0, div_q};

   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      rem_nxt = rem_q[SIG_W-1:0];
      if (!diff[SIG_W]) begin
         rem_nxt = diff[SIG_W-1:0];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         div_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         rem_q <= {1'b0, dividend};
         div_q <= divisor;
         quo_q <= '0;
         cnt_q <= iters;
      end else if (cnt_q != '0) begin
         quo_q <= {quo_q[SIG_W-1:0], ~diff[SIG_W]};
         rem_q <= {rem_nxt, 1'b0};
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign quotient = quo_q;
   assign done     = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fpu_div.sv
// Iterative IEEE 754 half/single divider with valid/ready handshake,
// truncating rounding and denormal flush-to-zero.
module fpu_div
   import fpu_pkg::*;
#(
   parameter int FLUSH_DENORM = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        prec,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        div_by_zero
);

   if (FLUSH_DENORM != 1) begin : g_flush_check
      $error("fpu_div: only FLUSH_DENORM = 1 is supported");
   end

   state_t            state_q, state_nxt;
   logic              prec_q, sign_q;
   logic signed [9:0] exp_q, exp_acc, e_norm, e_max;
   logic [31:0]       result_q, result_nxt, sp_result;
   logic              dbz_q, dbz_nxt, sp_dbz;
   fp_fields_t        ua, ub;
   logic              sign_x, accept, special, start, div_done;
   logic [SIG_W-1:0]  sig_a, sig_b;
   logic [SIG_W:0]    quo;
   logic [22:0]       man_norm;

   assign ua      = fp_unpack(a, prec);
   assign ub      = fp_unpack(b, prec);
   assign sign_x  = ua.sign ^ ub.sign;
   assign accept  = in_valid && (state_q == IDLE);
   assign start   = accept && !special;
   assign sig_a   = prec ? {1'b1, ua.man} : {13'd0, 1'b1, ua.man[9:0]};
   assign sig_b   = prec ? {1'b1, ub.man} : {13'd0, 1'b1, ub.man[9:0]};
   assign exp_acc = $signed({2'b00, ua.exp}) - $signed({2'b00, ub.exp}) + (prec ? SP_BIAS : HP_BIAS);

   fpu_mant_div u_mant_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .dividend (sig_a),
      .divisor  (sig_b),
      .iters    (prec ? CNT_W'(ITER_SP) : CNT_W'(ITER_HP)),
      .quotient (quo),
      .done     (div_done)
   );

   // NaN rules take priority, then Inf dividend, then zero results, then x/0.
   always_comb begin
      sp_result = '0;
      sp_dbz    = 1'b0;
      special   = 1'b1;
      if (ua.is_nan || ub.is_nan || (ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
         sp_result = prec ? NAN_SP : NAN_HP;
      end else if (ua.is_inf) begin
         sp_result = fp_inf(prec, sign_x);
      end else if (ub.is_inf || ua.is_zero) begin
         sp_result = fp_zero(prec, sign_x);
      end else if (ub.is_zero) begin
         sp_result = fp_inf(prec, sign_x);
         sp_dbz    = 1'b1;
      end else begin
         special   = 1'b0;
      end
   end

   // Quotient is in [0.5, 2): a leading zero costs one bit and one exponent step.
   always_comb begin
      man_norm = '0;
      e_norm   = exp_q;
      e_max    = prec_q ? SP_EMAX : HP_EMAX;
      if (prec_q) begin
         if (quo[ITER_SP-1]) begin
            man_norm = quo[ITER_SP-2:1];
         end else begin
            man_norm = quo[ITER_SP-3:0];
            e_norm   = exp_q - 10'sd1;
         end
      end else begin
         if (quo[ITER_HP-1]) begin
            man_norm = {13'd0, quo[ITER_HP-2:1]};
         end else begin
            man_norm = {13'd0, quo[ITER_HP-3:0]};
            e_norm   = exp_q - 10'sd1;
         end
      end
   end

   always_comb begin
      state_nxt  = state_q;
      result_nxt = result_q;
      dbz_nxt    = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (special) begin
                  state_nxt  = DONE;
                  result_nxt = sp_result;
                  dbz_nxt    = sp_dbz;
               end else begin
                  state_nxt  = DIV;
               end
            end
         end
         DIV: begin
            if (div_done) state_nxt = NORM;
         end
         NORM: begin
            state_nxt = DONE;
            dbz_nxt   = 1'b0;
            if (e_norm >= e_max) begin
               result_nxt = fp_inf(prec_q, sign_q);
            end else if (e_norm <= 10'sd0) begin
               result_nxt = fp_zero(prec_q, sign_q);
            end else begin
               result_nxt = fp_pack(prec_q, sign_q, e_norm[7:0], man_norm);
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         dbz_q    <= 1'b0;
         prec_q   <= 1'b0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
      end else begin
         state_q  <= state_nxt;
         result_q <= result_nxt;
         dbz_q    <= dbz_nxt;
         if (accept) begin
            prec_q <= prec;
            sign_q <= sign_x;
            exp_q  <= exp_acc;
         end
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fpu_div.sv
// Self-checking bench for fpu_div: directed cases, handshake/reset scenarios
// and random operands checked against an arithmetic reference model.
module tb_fpu_div;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        prec;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        div_by_zero;

   int n_cmp = 0;
   int n_mis = 0;

   fpu_div #(.FLUSH_DENORM(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .prec        (prec),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] enc(input logic single, input bit s, input longint e, input longint m);
      longint v;
      v = (longint'(s) << (single ? 31 : 15)) | (e << (single ? 23 : 10)) | m;
      return 32'(v);
   endfunction

   // Value-level model: exact truncated ratio of the two significands.
   function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input logic single,
                                   output logic [31:0] r, output logic z, output bit special);
      int     mw, bias, emax;
      longint ea, eb, ma, mb, siga, sigb, e, mant;
      bit     s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
      mw   = single ? 23 : 10;
      bias = single ? 127 : 15;
      emax = single ? 255 : 31;
      if (single) begin
         s  = x[31] ^ y[31];
         ea = longint'(x[30:23]); eb = longint'(y[30:23]);
         ma = longint'(x[22:0]);  mb = longint'(y[22:0]);
      end else begin
         s  = x[15] ^ y[15];
         ea = longint'(x[14:10]); eb = longint'(y[14:10]);
         ma = longint'(x[9:0]);   mb = longint'(y[9:0]);
      end
      nan_a  = (ea == emax) && (ma != 0);
      nan_b  = (eb == emax) && (mb != 0);
      inf_a  = (ea == emax) && (ma == 0);
      inf_b  = (eb == emax) && (mb == 0);
      zero_a = (ea == 0);
      zero_b = (eb == 0);
      z       = 1'b0;
      special = 1'b1;
      if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
         r = single ? 32'h7FC0_0000 : 32'h0000_7E00;
      end else if (inf_a) begin
         r = enc(single, s, emax, 0);
      end else if (inf_b || zero_a) begin
         r = enc(single, s, 0, 0);
      end else if (zero_b) begin
         r = enc(single, s, emax, 0);
         z = 1'b1;
      end else begin
         special = 1'b0;
         siga = (longint'(1) << mw) + ma;
         sigb = (longint'(1) << mw) + mb;
         e    = ea - eb + bias;
         if (siga >= sigb) begin
            mant = ((siga << mw) / sigb) - (longint'(1) << mw);
         end else begin
            mant = ((siga << (mw + 1)) / sigb) - (longint'(1) << mw);
            e    = e - 1;
         end
         if (e >= emax)   r = enc(single, s, emax, 0);
         else if (e <= 0) r = enc(single, s, 0, 0);
         else             r = enc(single, s, e, mant);
      end
   endfunction

   function automatic logic [31:0] rand_fp(input logic single);
      logic [31:0] x;
      int          sel;
      x   = $urandom;
      sel = $urandom_range(0, 15);
      if (single) begin
         if (sel == 0)      x[30:23] = 8'h00;
         else if (sel == 1) x[30:23] = 8'hFF;
         else if (sel == 2) begin x[30:23] = 8'hFF; x[22:0] = '0; end
         else if (sel == 3) x[30:23] = 8'($urandom_range(200, 254));
         else if (sel == 4) x[30:23] = 8'($urandom_range(1, 40));
         else               x[30:23] = 8'($urandom_range(100, 160));
      end else begin
         if (sel == 0)      x[14:10] = 5'h00;
         else if (sel == 1) x[14:10] = 5'h1F;
         else if (sel == 2) begin x[14:10] = 5'h1F; x[9:0] = '0; end
         else               x[14:10] = 5'($urandom_range(1, 30));
      end
      return x;
   endfunction

   // Accept at the next rising edge; latency counts that edge as 1.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_op, input logic tp,
                         output logic [31:0] r, output logic z, output int lat);
      @(negedge clk);
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      a = ta; b = tb_op; prec = tp; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; prec = ~tp; a = $urandom; b = $urandom;
      lat = 1;
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r = result;
      z = div_by_zero;
      @(posedge clk);
      #1;
   endtask

   task automatic check_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_op,
                           input logic tp, input logic [31:0] er, input logic ez, input int elat);
      logic [31:0] r;
      logic        z;
      int          lat;
      run_op(ta, tb_op, tp, r, z, lat);
      check({tag, "_result"}, r, er);
      check({tag, "_dbz"}, 32'(z), 32'(ez));
      check({tag, "_latency"}, 32'(lat), 32'(elat));
   endtask

   initial begin
      logic [31:0] ra, rb, er;
      logic        rp, ez;
      bit          sp;
      int          lat;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; prec = 1'b0; a = '0; b = '0;
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      check_op("sp_6_div_2",   32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 1'b0, 27);
      check_op("hp_1_div_3",   32'h0000_3C00, 32'h0000_4200, 1'b0, 32'h0000_3555, 1'b0, 14);
      check_op("sp_1_div_0",   32'h3F80_0000, 32'h0000_0000, 1'b1, 32'h7F80_0000, 1'b1, 1);
      check_op("sp_0_div_0",   32'h0000_0000, 32'h0000_0000, 1'b1, 32'h7FC0_0000, 1'b0, 1);
      check_op("hp_inf_inf",   32'h0000_7C00, 32'h0000_7C00, 1'b0, 32'h0000_7E00, 1'b0, 1);
      check_op("sp_overflow",  32'h7F00_0000, 32'h3E80_0000, 1'b1, 32'h7F80_0000, 1'b0, 27);
      check_op("sp_underflow", 32'h0080_0000, 32'h4000_0000, 1'b1, 32'h0000_0000, 1'b0, 27);
      check_op("sp_sign",      32'hC0C0_0000, 32'h4000_0000, 1'b1, 32'hC040_0000, 1'b0, 27);
      check_op("hp_neg_div_0", 32'hFFFF_BC00, 32'h0000_0000, 1'b0, 32'h0000_FC00, 1'b1, 1);
      check_op("sp_inf_num",   32'hFF80_0000, 32'h4000_0000, 1'b1, 32'hFF80_0000, 1'b0, 1);
      check_op("sp_num_inf",   32'h4000_0000, 32'hFF80_0000, 1'b1, 32'h8000_0000, 1'b0, 1);
      check_op("sp_denorm_a",  32'h0000_0001, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, 1);
      check_op("hp_nan",       32'h0000_7C01, 32'h0000_3C00, 1'b0, 32'h0000_7E00, 1'b0, 1);

      // Backpressure: result held, no accept while DONE waits for out_ready.
      out_ready = 1'b0;
      @(negedge clk);
      a = 32'h40C0_0000; b = 32'h4000_0000; prec = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("bp_latency", 32'(lat), 32'd27);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 2) begin
            a = 32'h4120_0000; b = 32'h40A0_0000; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         check("bp_result_stable", result, 32'h4040_0000);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_after_hs_in_ready", 32'(in_ready), 32'd1);
      check("bp_after_hs_out_valid", 32'(out_valid), 32'd0);
      check_op("bp_next_op", 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h3F00_0000, 1'b0, 27);

      // Reset in cycle 10 of a single-precision divide.
      @(negedge clk);
      a = 32'h40C0_0000; b = 32'h4000_0000; prec = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_in_ready", 32'(in_ready), 32'd1);
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("rst_discarded_out_valid", 32'(out_valid), 32'd0);
      check_op("rst_10_div_5", 32'h4120_0000, 32'h40A0_0000, 1'b1, 32'h4000_0000, 1'b0, 27);

      for (int i = 0; i < 60; i++) begin
         rp = 1'($urandom_range(0, 1));
         ra = rand_fp(rp);
         rb = rand_fp(rp);
         ref_div(ra, rb, rp, er, ez, sp);
         check_op("rand", ra, rb, rp, er, ez, sp ? 1 : (rp ? 27 : 14));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
